// File: rtl/picomips_io_seq.sv
// Switch/LED sequencer for the picoMips transform core: debounces the SW8 handshake,
// captures x1/y1, starts the core, waits for done with a timeout, then pages x2/y2 onto LED.
module picomips_io_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CALC_TIMEOUT    = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SW8,
  input  logic [7:0] SW_data,
  output logic [7:0] x1,
  output logic [7:0] y1,
  output logic       start,
  input  logic       done,
  input  logic [7:0] x2,
  input  logic [7:0] y2,
  output logic [7:0] LED,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WX_HI  = 3'd0,
    WX_LO  = 3'd1,
    WY_HI  = 3'd2,
    WY_LO  = 3'd3,
    CALC   = 3'd4,
    SHOW_X = 3'd5,
    SHOW_Y = 3'd6
  } state_t;

  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(CALC_TIMEOUT - 1);

  logic        sync1, sync2;
  logic        db;
  logic [7:0]  cnt;
  logic        rise, fall;
  state_t      fsm;
  logic [15:0] tmr;
  logic [7:0]  y2r;

  assign state = fsm;

  // Two-flop synchroniser feeding a stable-run debouncer; rise/fall are registered pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= SW8;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db   <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fsm   <= WX_HI;
      x1    <= '0;
      y1    <= '0;
      LED   <= '0;
      start <= 1'b0;
      err   <= 1'b0;
      tmr   <= '0;
      y2r   <= '0;
    end else begin
      start <= 1'b0;
      case (fsm)
        WX_HI: if (rise) begin
          x1  <= SW_data;
          fsm <= WX_LO;
        end
        WX_LO: if (fall) fsm <= WY_HI;
        WY_HI: if (rise) begin
          y1  <= SW_data;
          fsm <= WY_LO;
        end
        WY_LO: if (fall) begin
          fsm   <= CALC;
          start <= 1'b1;
          tmr   <= '0;
        end
        CALC: begin
          // start is high only in the first CALC cycle, so it masks done there;
          // done is tested before the timeout so a same-cycle done wins.
          if (done && !start) begin
            y2r <= y2;
            LED <= x2;
            err <= 1'b0;
            fsm <= SHOW_X;
          end else if (tmr == TMO_LAST) begin
            err <= 1'b1;
            LED <= 8'hFF;
            fsm <= WX_HI;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        SHOW_X: if (rise) begin
          LED <= y2r;
          fsm <= SHOW_Y;
        end
        SHOW_Y: if (fall) fsm <= WX_HI;
        default: fsm <= WX_HI;
      endcase
    end
  end

endmodule
